// File: rtl/dram_bridge_pkg.sv
// dram_bridge_pkg: bus widths, FSM state encoding and address helper shared by
// the data-RAM bridge, its bus interface and the bench.
package dram_bridge_pkg;

  localparam int DataBus = 32;
  localparam int AddrBus = 32;
  localparam int WriteEn = 4;

  typedef enum logic [1:0] {
    DBR_IDLE = 2'd0,
    DBR_REQ  = 2'd1,
    DBR_DONE = 2'd2,
    DBR_POST = 2'd3
  } dbr_state_e;

  // Reads always fetch the whole word; the pipeline picks the lane itself.
  function automatic logic [AddrBus-1:0] word_align(input logic [AddrBus-1:0] addr);
    return {addr[AddrBus-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/dram_bridge_if.sv
// dram_bridge_if: single req/ack transaction bus between the data-RAM bridge
// (master) and the memory controller or interconnect (slave).
interface dram_bridge_if;
  import dram_bridge_pkg::*;

  logic               bus_req;
  logic               bus_wr;
  logic [AddrBus-1:0] bus_addr;
  logic [WriteEn-1:0] bus_wstrb;
  logic [DataBus-1:0] bus_wdata;
  logic               bus_ack;
  logic [DataBus-1:0] bus_rdata;

  modport master (
    output bus_req, bus_wr, bus_addr, bus_wstrb, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_wr, bus_addr, bus_wstrb, bus_wdata,
    output bus_ack, bus_rdata
  );

endinterface

// File: rtl/dram_bridge.sv
// dram_bridge: responder side of the CPU data-RAM port. Each MEM-stage access
// becomes one req/ack transaction on the external bus while dram_sreq stalls
// the pipeline. Optional macro DRAM_BRIDGE_POST_WRITE_EN lets stores retire in
// one cycle and drain on the bus (POST state) while the pipeline moves on.
module dram_bridge
  import dram_bridge_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               dram_en,
  input  logic [AddrBus-1:0] dram_addr,
  input  logic [WriteEn-1:0] dram_wen,
  input  logic [DataBus-1:0] dram_wdata,
  output logic [DataBus-1:0] dram_rdata,
  output logic               dram_sreq,
  dram_bridge_if.master      dbus
);

  dbr_state_e state;
  logic       is_store;

  assign is_store = |dram_wen;

  // FSM plus every registered output; a flushed access still completes on the bus
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= DBR_IDLE;
      dbus.bus_req   <= 1'b0;
      dbus.bus_wr    <= 1'b0;
      dbus.bus_addr  <= '0;
      dbus.bus_wstrb <= '0;
      dbus.bus_wdata <= '0;
      dram_rdata     <= '0;
    end else begin
      case (state)
        DBR_IDLE: begin
          if (dram_en) begin
            dbus.bus_req   <= 1'b1;
            dbus.bus_wr    <= is_store;
            dbus.bus_addr  <= is_store ? dram_addr : word_align(dram_addr);
            dbus.bus_wstrb <= dram_wen;
            dbus.bus_wdata <= dram_wdata;
`ifdef DRAM_BRIDGE_POST_WRITE_EN
            state          <= is_store ? DBR_POST : DBR_REQ;
`else
            state          <= DBR_REQ;
`endif
          end
        end
        DBR_REQ: begin
          if (dbus.bus_ack) begin
            dbus.bus_req <= 1'b0;
            if (!dbus.bus_wr) dram_rdata <= dbus.bus_rdata;
            state        <= DBR_DONE;
          end
        end
        DBR_DONE: begin
          state <= DBR_IDLE;
        end
`ifdef DRAM_BRIDGE_POST_WRITE_EN
        DBR_POST: begin
          if (dbus.bus_ack) begin
            dbus.bus_req <= 1'b0;
            state        <= DBR_IDLE;
          end
        end
`endif
        default: begin
          dbus.bus_req <= 1'b0;
          state        <= DBR_IDLE;
        end
      endcase
    end
  end

`ifdef DRAM_BRIDGE_POST_WRITE_EN
  // A store accepted in IDLE is latched and retires immediately; anything
  // arriving during POST waits for the drain.
  assign dram_sreq = dram_en && (state != DBR_DONE) && !((state == DBR_IDLE) && is_store);
`else
  // The pipeline only advances in the DONE cycle.
  assign dram_sreq = dram_en && (state != DBR_DONE);
`endif

endmodule

// File: tb/tb_dram_bridge.sv
// tb_dram_bridge: scoreboard bench for dram_bridge. Expected bus fields, read
// data and stall length are queued when an access is driven and compared when
// the bridge issues the transaction and reaches DONE.
`timescale 1ns/1ps
module tb_dram_bridge;
  import dram_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        dram_en;
  logic [31:0] dram_addr;
  logic [3:0]  dram_wen;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata;
  logic        dram_sreq;

  dram_bridge_if dbus ();

  dram_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .dram_en    (dram_en),
    .dram_addr  (dram_addr),
    .dram_wen   (dram_wen),
    .dram_wdata (dram_wdata),
    .dram_rdata (dram_rdata),
    .dram_sreq  (dram_sreq),
    .dbus       (dbus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stall;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] model_rdata;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the IDLE after DONE.
  task automatic access(input logic [31:0] addr, input logic [3:0] wen,
                        input logic [31:0] wdata, input int delay, input logic [31:0] rd);
    exp_t e;
    exp_t got;
    int   stall = 0;
    int   nreq  = 0;
    bit   done  = 0;
    bit   seen  = 0;
    e.addr  = (wen != 4'd0) ? addr : {addr[31:2], 2'b00};
    e.wr    = (wen != 4'd0);
    e.wstrb = wen;
    e.wdata = wdata;
    e.rdata = (wen != 4'd0) ? model_rdata : rd;
    e.stall = 2 + delay;
    model_rdata = e.rdata;
    sb.push_back(e);
    got = e;
    check_val("idle_bus_req", {31'd0, dbus.bus_req}, 32'd0);
    dram_en    = 1'b1;
    dram_addr  = addr;
    dram_wen   = wen;
    dram_wdata = wdata;
    for (int c = 0; c < 64 && !done; c++) begin
      if (dbus.bus_req) begin
        if (!seen) begin
          seen = 1;
          got  = sb.pop_front();
          check_val("bus_addr",  dbus.bus_addr,            got.addr);
          check_val("bus_wr",    {31'd0, dbus.bus_wr},     {31'd0, got.wr});
          check_val("bus_wstrb", {28'd0, dbus.bus_wstrb},  {28'd0, got.wstrb});
          check_val("bus_wdata", dbus.bus_wdata,           got.wdata);
        end
        dbus.bus_ack   = (nreq == delay);
        dbus.bus_rdata = (nreq == delay) ? rd : 32'h0BAD0BAD;
        nreq++;
      end else begin
        dbus.bus_ack = 1'b0;
      end
      @(negedge clk);
      if (dram_sreq) begin
        stall++;
        @(posedge clk);
        #1;
      end else begin
        done = 1;
      end
    end
    check_val("access_done", {31'd0, done}, 32'd1);
    check_val("bus_req_seen", {31'd0, seen}, 32'd1);
    if (!seen) void'(sb.pop_front());
    check_val("stall_cycles", stall, got.stall);
    check_val("dram_rdata", dram_rdata, got.rdata);
    dram_en      = 1'b0;
    dbus.bus_ack = 1'b0;
    @(posedge clk);
    #1;
  endtask

`ifdef DRAM_BRIDGE_POST_WRITE_EN
  int p_stall;
  int p_nreq;
  bit p_seen;
`endif

  initial begin
    rst            = 1'b1;
    dram_en        = 1'b0;
    dram_addr      = '0;
    dram_wen       = '0;
    dram_wdata     = '0;
    dbus.bus_ack   = 1'b0;
    dbus.bus_rdata = '0;
    model_rdata    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    check_val("rst_bus_req",   {31'd0, dbus.bus_req},   32'd0);
    check_val("rst_bus_wr",    {31'd0, dbus.bus_wr},    32'd0);
    check_val("rst_bus_addr",  dbus.bus_addr,           32'd0);
    check_val("rst_bus_wstrb", {28'd0, dbus.bus_wstrb}, 32'd0);
    check_val("rst_bus_wdata", dbus.bus_wdata,          32'd0);
    check_val("rst_rdata",     dram_rdata,              32'd0);
    check_val("rst_sreq",      {31'd0, dram_sreq},      32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("idle_req",  {31'd0, dbus.bus_req}, 32'd0);
      check_val("idle_sreq", {31'd0, dram_sreq},    32'd0);
      @(posedge clk);
      #1;
    end

    access(32'h8000_1004, 4'b0000, 32'h0, 0, 32'hDEAD_BEEF);
    access(32'h8000_1007, 4'b0000, 32'h0, 2, 32'h1357_2468);
`ifndef DRAM_BRIDGE_POST_WRITE_EN
    access(32'h0000_0103, 4'b1000, 32'h5A5A_5A5A, 4, 32'h7777_7777);
    access(32'h0000_2002, 4'b1100, 32'hABCD_0000, 1, 32'h5555_5555);
`endif
    access(32'h0000_0010, 4'b0000, 32'h0, 0, 32'h1111_1111);
    access(32'h0000_0014, 4'b0000, 32'h0, 0, 32'h2222_2222);

    // Reset while a read is outstanding in REQ
    dram_en    = 1'b1;
    dram_addr  = 32'h0000_0300;
    dram_wen   = 4'b0000;
    dram_wdata = 32'h3C3C_3C3C;
    @(posedge clk);
    #1;
    check_val("req_before_rst", {31'd0, dbus.bus_req}, 32'd1);
    rst     = 1'b1;
    dram_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_rdata = 32'd0;
    check_val("mid_rst_bus_req",   {31'd0, dbus.bus_req},   32'd0);
    check_val("mid_rst_bus_wr",    {31'd0, dbus.bus_wr},    32'd0);
    check_val("mid_rst_bus_addr",  dbus.bus_addr,           32'd0);
    check_val("mid_rst_bus_wstrb", {28'd0, dbus.bus_wstrb}, 32'd0);
    check_val("mid_rst_bus_wdata", dbus.bus_wdata,          32'd0);
    check_val("mid_rst_rdata",     dram_rdata,              32'd0);
    check_val("mid_rst_sreq",      {31'd0, dram_sreq},      32'd0);

    // Late ack arriving in IDLE must be ignored
    dbus.bus_ack   = 1'b1;
    dbus.bus_rdata = 32'hFFFF_0000;
    @(posedge clk);
    #1;
    dbus.bus_ack = 1'b0;
    check_val("stray_ack_rdata", dram_rdata, 32'd0);
    check_val("stray_ack_req",   {31'd0, dbus.bus_req}, 32'd0);
    access(32'h0000_0040, 4'b0000, 32'h0, 0, 32'h0F0F_0F0F);

`ifdef DRAM_BRIDGE_POST_WRITE_EN
    // Posted store followed immediately by a load
    dram_en    = 1'b1;
    dram_addr  = 32'h0000_0200;
    dram_wen   = 4'b1111;
    dram_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    check_val("post_sw_sreq", {31'd0, dram_sreq}, 32'd0);
    @(posedge clk);
    #1;
    check_val("post_bus_req",   {31'd0, dbus.bus_req}, 32'd1);
    check_val("post_bus_wr",    {31'd0, dbus.bus_wr},  32'd1);
    check_val("post_bus_addr",  dbus.bus_addr,         32'h0000_0200);
    check_val("post_bus_wdata", dbus.bus_wdata,        32'hCAFE_F00D);
    dram_addr = 32'h0000_0204;
    dram_wen  = 4'b0000;
    p_stall = 0;
    p_nreq  = 0;
    p_seen  = 0;
    for (int c = 0; c < 20 && !p_seen; c++) begin
      if (dbus.bus_req && !dbus.bus_wr) begin
        p_seen = 1;
      end else begin
        dbus.bus_ack = dbus.bus_req && (p_nreq == 2);
        if (dbus.bus_req) p_nreq++;
        @(negedge clk);
        if (dram_sreq) p_stall++;
        @(posedge clk);
        #1;
      end
    end
    check_val("post_lw_issued", {31'd0, p_seen}, 32'd1);
    check_val("post_lw_stall",  p_stall, 32'd4);
    check_val("post_lw_addr",   dbus.bus_addr, 32'h0000_0204);
    dbus.bus_ack   = 1'b1;
    dbus.bus_rdata = 32'h600D_D00D;
    @(negedge clk);
    check_val("post_lw_req_sreq", {31'd0, dram_sreq}, 32'd1);
    @(posedge clk);
    #1;
    dbus.bus_ack = 1'b0;
    @(negedge clk);
    check_val("post_lw_done_sreq", {31'd0, dram_sreq}, 32'd0);
    check_val("post_lw_rdata",     dram_rdata, 32'h600D_D00D);
    dram_en = 1'b0;
    @(posedge clk);
    #1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
